// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-cycle data-memory responder with byte/half/word access
//                and a one-deep valid/ready response stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int WIDTH = 32,
    parameter int DADDR = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [DADDR+1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err
);

    localparam int DEPTH = 2**DADDR;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic             r_rsp_err;

    logic             w_accept;
    logic             w_err;
    logic [1:0]       w_lane;
    logic [DADDR-1:0] w_widx;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_load;

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready && !reset;
    assign w_lane    = req_addr[1:0];
    assign w_widx    = req_addr[DADDR+1:2];
    assign w_word    = r_mem[w_widx];
    assign w_shifted = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_err = 1'b0;
        case (req_size)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = w_lane[0];
            2'd2:    w_err = (w_lane != 2'd0);
            default: w_err = 1'b1;
        endcase
    end

    // Replicated store data lets every enabled lane take its slice directly.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be    = 4'b0011 << w_lane;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_load = w_word;
        case (req_size)
            2'd0: w_load = req_unsigned ? {{(WIDTH-8){1'b0}}, w_shifted[7:0]}
                                        : {{(WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_load = req_unsigned ? {{(WIDTH-16){1'b0}}, w_shifted[15:0]}
                                        : {{(WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_word;
        endcase
    end

    // Storage is intentionally outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_widx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (req_we || w_err) ? '0 : w_load;
            r_rsp_err   <= w_err;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; only 32 supported.
REQ-002 SHALL have parameter DADDR, default 5, word-address bits; storage depth 2**DADDR words.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  DADDR+2  byte address.
REQ-011 SHALL have port req_wdata  input  WIDTH  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-014 SHALL have port rsp_rdata  output  WIDTH  load result; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned or illegal-size request.

Function
REQ-016 SHALL accept a request on any cycle where req_valid and req_ready are both 1.
REQ-017 SHALL drive req_ready = !rsp_valid || rsp_ready, combinationally.
REQ-018 SHALL assert rsp_valid exactly one cycle after acceptance, with rsp_rdata and rsp_err.
REQ-019 SHALL hold rsp_valid, rsp_rdata and rsp_err stable until the cycle rsp_ready is 1.
REQ-020 SHALL deassert rsp_valid after the consuming cycle unless a new request is accepted that same cycle.
REQ-021 SHALL sustain one request per cycle when rsp_ready stays 1.
REQ-022 SHALL store data little-endian: byte lane k = word bits [8k+7:8k], lane = req_addr[1:0], word = req_addr[DADDR+1:2].
REQ-023 SHALL treat halfword with req_addr[0]=1, word with req_addr[1:0]!=0, and any req_size=3 as errors.
REQ-024 SHALL, on error, leave storage unmodified and respond rsp_err=1, rsp_rdata=0.
REQ-025 SHALL perform stores at the acceptance clock edge, writing only the addressed lanes from req_wdata[7:0] or [15:0] or [31:0].
REQ-026 SHALL capture load data at the acceptance edge, so a load accepted the cycle after a store returns the stored value.
REQ-027 SHALL, for byte/halfword loads, select the addressed lanes and extend per req_unsigned to WIDTH bits.
REQ-028 SHALL respond to a successful store with rsp_err=0, rsp_rdata=0.
REQ-029 SHALL ignore req_we, req_size, req_addr and req_wdata when the request is not accepted.

Reset
REQ-030 SHALL, while reset=1, drive rsp_valid=0, rsp_err=0 and rsp_rdata=0 from the next edge.
REQ-031 SHALL give reset priority: a request presented in a cycle with reset=1 is neither written nor answered.
REQ-032 SHALL discard a pending response when reset asserts mid-handshake.
REQ-033 SHALL NOT clear storage contents on reset.

Verification
REQ-034 Store word 0xDEADBEEF to 0x04, then load word 0x04 -> rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after each accept.
REQ-035 After REQ-034, store byte 0x5A to 0x06, then load signed byte 0x07 -> 0xFFFFFFDE; load unsigned half 0x06 -> 0x0000DE5A; load word 0x04 -> 0xDE5ABEEF.
REQ-036 Load half at 0x05 and word at 0x06, store with req_size=3 -> rsp_err=1, rsp_rdata=0, word 0x04 unchanged.
REQ-037 Hold rsp_ready=0 for 3 cycles after a load -> rsp_valid and data stable, req_ready=0; rsp_ready=1 with a new req_valid -> back-to-back accept, rsp_valid stays 1.
REQ-038 Assert reset one cycle while rsp_valid=1 -> rsp_valid=0 next cycle, no further response; storage retains prior values.
REQ-039 Stream 8 alternating store/load requests with rsp_ready=1 -> 8 responses in 8 consecutive cycles, each load returning the preceding store's data.
